// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI constants, AR channel state encoding and counter width for the
// instruction-side read bridge.
package inst_axi_rd_bridge_pkg;

    localparam int CNT_W = 3;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

endpackage

// File: rtl/inst_axi_rd_bridge_track_cnt.sv
// Outstanding-read and cancelled-read bookkeeping for the instruction bridge.
module rd_track_cnt
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic accept,
    input  logic r_hs,
    output logic can_accept,
    output logic beat_live
);

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] cancel_cnt;
    logic             beat;

    // A beat with nothing outstanding is a slave protocol error; ignoring it
    // keeps the counter from wrapping.
    assign beat       = r_hs && (outstanding != '0);
    assign beat_live  = beat && (cancel_cnt == '0);
    assign can_accept = outstanding < CNT_W'(MAX_OUTSTANDING);

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            cancel_cnt  <= '0;
        end else begin
            case ({accept, beat})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            // Everything still owed when flush hits is stale, except the beat
            // retiring in this same cycle.
            if (flush) begin
                cancel_cnt <= outstanding - CNT_W'(beat);
            end else if (beat && (cancel_cnt != '0)) begin
                cancel_cnt <= cancel_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Converts sram-like instruction fetch reads into single-beat in-order AXI4
// reads, dropping the data of reads cancelled by an exception flush.
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        bus_err
);

    ar_state_t ar_state;
    logic      r_hs;
    logic      can_accept;
    logic      beat_live;
    logic      unused_r_fields;

    // In-order single-beat responses make rid and rlast redundant.
    assign unused_r_fields = ^{rid, rlast};

    assign rready = !reset;
    assign r_hs   = rvalid && rready;

    assign inst_sram_addrok = (ar_state == AR_IDLE) && inst_sram_req && !inst_sram_wr
                              && !flush && can_accept;
    assign inst_sram_dataok = beat_live;
    assign inst_sram_rdata  = rdata;
    assign bus_err          = beat_live && (rresp != RESP_OKAY);

    assign arid    = AXI_ID;
    assign arlen   = '0;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    // A flush never withdraws a pending AR; that read is already counted and
    // its data is discarded on return.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            arsize   <= '0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (inst_sram_addrok) begin
                        ar_state <= AR_SEND;
                        arvalid  <= 1'b1;
                        araddr   <= inst_sram_addr;
                        arsize   <= {1'b0, inst_sram_size};
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        ar_state <= AR_IDLE;
                        arvalid  <= 1'b0;
                    end
                end
                default: begin
                    ar_state <= AR_IDLE;
                    arvalid  <= 1'b0;
                end
            endcase
        end
    end

    rd_track_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_track (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .accept    (inst_sram_addrok),
        .r_hs      (r_hs),
        .can_accept(can_accept),
        .beat_live (beat_live)
    );

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized bench for inst_axi_rd_bridge against a queue-based fetch/AXI model.
module tb_inst_axi_rd_bridge;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addrok;
    logic        inst_sram_dataok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(
        .MAX_OUTSTANDING(MAX),
        .AXI_ID         (4'd0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .inst_sram_req   (inst_sram_req),
        .inst_sram_wr    (inst_sram_wr),
        .inst_sram_size  (inst_sram_size),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_addrok(inst_sram_addrok),
        .inst_sram_dataok(inst_sram_dataok),
        .inst_sram_rdata (inst_sram_rdata),
        .arid            (arid),
        .araddr          (araddr),
        .arlen           (arlen),
        .arsize          (arsize),
        .arburst         (arburst),
        .arlock          (arlock),
        .arcache         (arcache),
        .arprot          (arprot),
        .arvalid         (arvalid),
        .arready         (arready),
        .rid             (rid),
        .rdata           (rdata),
        .rresp           (rresp),
        .rlast           (rlast),
        .rvalid          (rvalid),
        .rready          (rready),
        .bus_err         (bus_err)
    );

    // Fetch-side view: every accepted read, in order, and whether a flush killed it.
    typedef struct {
        logic [31:0] addr;
        bit          cancelled;
    } fetch_t;
    // Slave-side view: addresses seen on AR and the cycle their beat may return.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } beat_t;

    fetch_t      mq[$];
    beat_t       sq[$];
    bit          ar_busy;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    bit          last_ok;
    int          cyc;
    int          checks;
    int          errors;
    int          n_dataok;
    int          n_berr;
    int          ar_pct;
    int          r_pct;
    int          lat_min;
    int          lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h83c10001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rq, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic fl);
        bit     exp_ok;
        bit     exp_dok;
        bit     exp_berr;
        fetch_t fr;
        @(posedge clk);
        #1;
        cyc++;
        inst_sram_req  = rq;
        inst_sram_wr   = w;
        inst_sram_size = sz;
        inst_sram_addr = a;
        flush          = fl;
        arready        = ($urandom_range(99) < ar_pct);
        if (sq.size() > 0 && sq[0].due <= cyc && $urandom_range(99) < r_pct) begin
            rvalid = 1'b1;
            rdata  = mem_word(sq[0].addr);
            rresp  = ($urandom_range(4) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'b00;
        end
        #4;
        exp_ok   = rq && !w && !fl && !ar_busy && (mq.size() < MAX);
        exp_dok  = 1'b0;
        exp_berr = 1'b0;
        check("addr_ok", 32'(inst_sram_addrok), 32'(exp_ok));
        check("arvalid", 32'(arvalid), 32'(ar_busy));
        check("rready", 32'(rready), 32'd1);
        if (ar_busy) begin
            check("araddr", araddr, ar_addr);
            check("arsize", 32'(arsize), 32'(ar_size));
        end
        if (rvalid) begin
            if (mq.size() == 0) begin
                check("r_protocol", 32'd0, 32'd1);
            end else begin
                fr       = mq.pop_front();
                exp_dok  = !fr.cancelled;
                exp_berr = exp_dok && (rresp != 2'b00);
            end
            void'(sq.pop_front());
        end
        check("data_ok", 32'(inst_sram_dataok), 32'(exp_dok));
        check("bus_err", 32'(bus_err), 32'(exp_berr));
        if (exp_dok) check("rdata", inst_sram_rdata, mem_word(fr.addr));
        n_dataok += int'(inst_sram_dataok);
        n_berr   += int'(bus_err);

        if (arvalid && arready) sq.push_back('{araddr, cyc + $urandom_range(lat_max, lat_min)});
        if (ar_busy && arready) ar_busy = 1'b0;
        if (exp_ok) begin
            mq.push_back('{a, 1'b0});
            ar_busy = 1'b1;
            ar_addr = a;
            ar_size = {1'b0, sz};
        end
        if (fl) foreach (mq[i]) mq[i].cancelled = 1'b1;
        last_ok = exp_ok;
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        inst_sram_req = 1'b0;
        flush         = 1'b0;
        rvalid        = 1'b0;
        arready       = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #5;
            check("rst_rready", 32'(rready), 32'd0);
            check("rst_arvalid", 32'(arvalid), 32'd0);
            check("rst_araddr", araddr, 32'd0);
            check("rst_addrok", 32'(inst_sram_addrok), 32'd0);
            check("rst_dataok", 32'(inst_sram_dataok), 32'd0);
            check("rst_buserr", 32'(bus_err), 32'd0);
        end
        mq.delete();
        sq.delete();
        ar_busy = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a);
        int k;
        k = 0;
        do begin
            step(1'b1, 1'b0, 2'd2, a, 1'b0);
            k++;
        end while (!last_ok && k < 40);
        if (!last_ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        cyc = 0; checks = 0; errors = 0; n_dataok = 0; n_berr = 0;
        inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = '0;
        rid = 4'd0; rlast = 1'b1; rdata = '0; rresp = 2'b00;
        ar_pct = 100; r_pct = 100; lat_min = 3; lat_max = 3;
        ar_busy = 1'b0; last_ok = 1'b0;
        do_reset(3);

        check("arlen", 32'(arlen), 32'd0);
        check("arburst", 32'(arburst), 32'd1);
        check("arid", 32'(arid), 32'd0);
        check("ar_misc", 32'({arlock, arcache, arprot}), 32'd0);

        // Single fetch: accepted at once, one live beat 3 cycles after AR.
        base = n_dataok;
        step(1'b1, 1'b0, 2'd2, 32'hbfc00000, 1'b0);
        check("single_accept", 32'(last_ok), 32'd1);
        idle(8);
        check("single_count", 32'(n_dataok - base), 32'd1);

        // Back-to-back with slave latency 5; third request must wait.
        lat_min = 5; lat_max = 5; base = n_dataok;
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        idle(15);
        check("b2b_count", 32'(n_dataok - base), 32'd3);

        // AR held off for several cycles while the request stays asserted.
        ar_pct = 0; lat_min = 2; lat_max = 2;
        step(1'b1, 1'b0, 2'd2, 32'h40, 1'b0);
        repeat (4) step(1'b1, 1'b0, 2'd2, 32'h44, 1'b0);
        ar_pct = 100;
        idle(8);

        // Two reads in flight, flush, then a new fetch: only the new one returns.
        lat_min = 6; lat_max = 6; base = n_dataok;
        fetch(32'h100); fetch(32'h104);
        step(1'b1, 1'b0, 2'd2, 32'h200, 1'b1);
        fetch(32'h380);
        idle(20);
        check("flush_count", 32'(n_dataok - base), 32'd1);

        // Random traffic with a reset dropped in mid-stream.
        ar_pct = 70; r_pct = 75; lat_min = 1; lat_max = 5;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset(2);
            step(($urandom_range(2) != 0), ($urandom_range(7) == 0),
                 2'($urandom_range(2)), $urandom & 32'hfffffffc,
                 ($urandom_range(24) == 0));
        end

        ar_pct = 100; r_pct = 100;
        for (int i = 0; i < 60 && (mq.size() != 0 || ar_busy); i++) idle(1);
        check("drain_empty", 32'(mq.size()), 32'd0);
        check("saw_bus_err", 32'(n_berr > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
Instruction-side bridge that converts the fetch unit's sram-like read requests into AXI4 read-address and read-data transactions. It returns addr_ok and data_ok back to the fetch unit. It sits directly upstream of the fetch stage and tracks up to MAX_OUTSTANDING in-order reads. A flush from exception handling cancels in-flight reads, and their returning data is silently dropped.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unreturned reads (1..7)
AXI_ID, 4'd0, constant arid value; responses are in order

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  exception flush; cancels all reads accepted before this cycle
inst_sram_req  in  1  fetch read request
inst_sram_wr  in  1  write flag; a request with wr=1 is never accepted
inst_sram_size  in  2  log2 bytes; copied to arsize
inst_sram_addr  in  32  byte address
inst_sram_addrok  out  1  request accepted this cycle
inst_sram_dataok  out  1  read data valid this cycle
inst_sram_rdata  out  32  read data
arid  out  4  AXI_ID
araddr  out  32  read address
arlen  out  8  always 0
arsize  out  3  {1'b0, size}
arburst  out  2  always 2'b01
arlock/arcache/arprot  out  2/4/3  always 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored
rdata  in  32  read data
rresp  in  2  captured into bus_err
rlast  in  1  ignored (single beat)
rvalid  in  1  R valid
rready  out  1  always 1 after reset
bus_err  out  1  one-cycle pulse on a non-cancelled beat with rresp!=0

Behaviour:
- Reset values: arvalid=0, araddr=0, addr_ok=0, data_ok=0, bus_err=0, outstanding=0, cancel_cnt=0, AR FSM=AR_IDLE. rready=0 during reset and 1 otherwise.
- AR FSM, two states:
  - AR_IDLE: addr_ok = req && !wr && !flush && outstanding<MAX_OUTSTANDING. Combinational, same cycle as req. On accept, latch addr and size; next state AR_SEND, with arvalid=1 from the next cycle.
  - AR_SEND: arvalid held and araddr stable until arready. On handshake, go to AR_IDLE. addr_ok=0 while in AR_SEND. Minimum one request per 2 cycles.
- outstanding (3 bits): +1 on addr_ok, -1 on R handshake (rvalid&&rready). Both in the same cycle leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- flush:
  - cancel_cnt <= outstanding (minus 1 if an R handshake occurs in the same cycle).
  - Flush forces addr_ok=0 that cycle.
  - A pending arvalid in AR_SEND is NOT withdrawn. It completes normally and is already counted in outstanding, so its data is discarded.
  - A second flush while cancel_cnt>0 reloads cancel_cnt with the same rule.
- R handshake with cancel_cnt>0: cancel_cnt-1, data_ok=0, bus_err=0.
- R handshake with cancel_cnt==0: data_ok=1 and rdata passed through combinationally. bus_err=(rresp!=0).
- data_ok is never asserted without an outstanding non-cancelled read. An rvalid with outstanding==0 is a protocol error; the bench flags it.
- Accept-after-flush: new requests accepted in later cycles are returned normally once cancel_cnt drains. AXI ordering guarantees the cancelled data arrives first.
- Reset mid-transaction clears all state. The AXI slave is reset by the same reset.

Decomposition:
- Shared package/header holds:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - AR_IDLE/AR_SEND state encodings.
  - CNT_W width macro.
- One natural sub-module: rd_track_cnt. It holds the outstanding and cancel counters with the flush-reload rule, kept separate from the AR FSM.

Test Plan:
- Single fetch, addr 0xbfc00000, arready=1 at once, rvalid 3 cycles later with rdata=0x3c010001 -> addr_ok at cycle 0, arvalid cycle 1, data_ok with rdata=0x3c010001 exactly once.
- Back-to-back reqs 0x0/0x4/0x8, arready always 1, slave latency 5 -> third req stalls until outstanding<2; data_ok order is 0x0, 0x4, 0x8.
- arready low for 4 cycles -> araddr stable, arvalid held, addr_ok=0 throughout, one AR handshake.
- Two reads outstanding, flush, then req 0x380 -> both old beats dropped (data_ok=0); data_ok for 0x380 only.
- Flush in the same cycle as req and as an R beat -> addr_ok=0, cancel_cnt=outstanding-1, no data_ok.
- rresp=2'b10 on a live beat -> data_ok=1 and bus_err pulse. On a cancelled beat -> neither.
